// File: rtl/traffic_light_monitor_if.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor_if
// Bundles the sampled controller pins and the monitor's decoded outputs.
//   master : drives lights/seg/err_clr, observes the monitor outputs
//   slave  : the monitor itself
// Signals:
//   lights[2:0]   {red,yellow,green} from the controller pins
//   seg[6:0]      7-segment pattern, bit0 = segment a
//   err_clr       single-cycle clear of the sticky error
//   phase[2:0]    decoded phase (0 UNSYNC .. 6 IDLE_BLINK)
//   digit[3:0]    decoded segment value 0-9, 4'hF when invalid
//   last_dur[7:0] length in cycles of the last completed phase
//   dur_stb       one-cycle pulse when last_dur updates
//   rounds[7:0]   completed RED->RED rounds, wrapping
//   err           sticky error flag
//   err_code[2:0] cause of the first error since clear
// -----------------------------------------------------------------------------
interface traffic_light_monitor_if;
  logic [2:0] lights;
  logic [6:0] seg;
  logic       err_clr;
  logic [2:0] phase;
  logic [3:0] digit;
  logic [7:0] last_dur;
  logic       dur_stb;
  logic [7:0] rounds;
  logic       err;
  logic [2:0] err_code;

  modport master (
    output lights, seg, err_clr,
    input  phase, digit, last_dur, dur_stb, rounds, err, err_code
  );

  modport slave (
    input  lights, seg, err_clr,
    output phase, digit, last_dur, dur_stb, rounds, err, err_code
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
// Passive checker for a traffic-light controller. Samples the lamp pins and
// the countdown display every cycle, tracks the light sequence with an FSM,
// measures phase lengths, counts rounds and latches the first protocol error.
// All outputs are registered (one cycle after the sampled inputs).
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - traffic_light_monitor_if.slave (see interface file for signals)
// Parameters:
//   MAX_PHASE - phase length in cycles that counts as a timeout
// Optional feature:
//   TLM_COUNTDOWN_CHECK_EN - when defined, the display must count down by one
//   each cycle while RED is held and show 0 outside RED (error code 4).
//
// Error codes: 1 illegal lamp combination, 2 illegal transition,
//              3 invalid segment pattern, 4 countdown violation, 5 timeout.
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int MAX_PHASE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  traffic_light_monitor_if.slave  bus
);

  // Encodings equal the phase numbers presented on bus.phase.
  typedef enum logic [2:0] {
    UNSYNC      = 3'd0,
    RED         = 3'd1,
    RED_YELLOW  = 3'd2,
    GREEN       = 3'd3,
    GREEN_BLINK = 3'd4,
    YELLOW      = 3'd5,
    IDLE_BLINK  = 3'd6
  } state_e;

  localparam logic [2:0] L_DARK = 3'd0;
  localparam logic [2:0] L_R    = 3'd1;
  localparam logic [2:0] L_RY   = 3'd2;
  localparam logic [2:0] L_G    = 3'd3;
  localparam logic [2:0] L_Y    = 3'd4;
  localparam logic [2:0] L_ILL  = 3'd7;

  localparam logic [7:0] MAX_CNT = 8'(MAX_PHASE);

  function automatic logic [2:0] decode_lights(input logic [2:0] l);
    case (l)
      3'b100:  decode_lights = L_R;
      3'b110:  decode_lights = L_RY;
      3'b001:  decode_lights = L_G;
      3'b010:  decode_lights = L_Y;
      3'b000:  decode_lights = L_DARK;
      default: decode_lights = L_ILL;
    endcase
  endfunction

  // Standard gfedcba patterns, bit0 = segment a.
  function automatic logic [3:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b0111111: decode_seg = 4'd0;
      7'b0000110: decode_seg = 4'd1;
      7'b1011011: decode_seg = 4'd2;
      7'b1001111: decode_seg = 4'd3;
      7'b1100110: decode_seg = 4'd4;
      7'b1101101: decode_seg = 4'd5;
      7'b1111101: decode_seg = 4'd6;
      7'b0000111: decode_seg = 4'd7;
      7'b1111111: decode_seg = 4'd8;
      7'b1101111: decode_seg = 4'd9;
      default:    decode_seg = 4'hF;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e     state_q, state_d;
  state_e     nom_state;
  logic [7:0] phase_cnt_q, phase_cnt_d;
  logic [3:0] digit_q, digit_d;
  logic [7:0] last_dur_q, last_dur_d;
  logic       dur_stb_q, dur_stb_d;
  logic [7:0] rounds_q, rounds_d;
  logic       err_q, err_d;
  logic [2:0] err_code_q, err_code_d;

  logic [2:0] lc;
  logic [3:0] dec_digit;
  logic       trans_ok;
  logic       timeout;
  logic       cd_bad;
  logic [2:0] cause;

  assign lc        = decode_lights(bus.lights);
  assign dec_digit = decode_seg(bus.seg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNSYNC;
      phase_cnt_q <= 8'd0;
      digit_q     <= 4'd0;
      last_dur_q  <= 8'd0;
      dur_stb_q   <= 1'b0;
      rounds_q    <= 8'd0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      digit_q     <= digit_d;
      last_dur_q  <= last_dur_d;
      dur_stb_q   <= dur_stb_d;
      rounds_q    <= rounds_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Nominal transition ignoring errors; trans_ok low marks an illegal move
  // out of a synced state. Illegal lamp codes are caught separately.
  always_comb begin
    nom_state = state_q;
    trans_ok  = 1'b1;
    case (state_q)
      UNSYNC: begin
        if (lc == L_R)                        nom_state = RED;
        else if (lc == L_DARK || lc == L_Y)   nom_state = IDLE_BLINK;
        else                                  nom_state = UNSYNC;
      end
      IDLE_BLINK: begin
        if (lc == L_DARK || lc == L_Y)        nom_state = IDLE_BLINK;
        else if (lc == L_R)                   nom_state = RED;
        else                                  trans_ok  = 1'b0;
      end
      RED: begin
        if (lc == L_R)                        nom_state = RED;
        else if (lc == L_RY)                  nom_state = RED_YELLOW;
        else                                  trans_ok  = 1'b0;
      end
      RED_YELLOW: begin
        if (lc == L_RY)                       nom_state = RED_YELLOW;
        else if (lc == L_G)                   nom_state = GREEN;
        else                                  trans_ok  = 1'b0;
      end
      GREEN: begin
        if (lc == L_G)                        nom_state = GREEN;
        else if (lc == L_DARK)                nom_state = GREEN_BLINK;
        else                                  trans_ok  = 1'b0;
      end
      GREEN_BLINK: begin
        if (lc == L_G || lc == L_DARK)        nom_state = GREEN_BLINK;
        else if (lc == L_Y)                   nom_state = YELLOW;
        else                                  trans_ok  = 1'b0;
      end
      YELLOW: begin
        if (lc == L_Y)                        nom_state = YELLOW;
        else if (lc == L_R)                   nom_state = RED;
        else                                  trans_ok  = 1'b0;
      end
      default: begin
        nom_state = UNSYNC;
      end
    endcase
  end

  // Error causes, next state and registered outputs.
  always_comb begin
    // Timeout fires on the edge where the count of a held timed phase
    // reaches the limit.
    timeout = (nom_state == state_q) &&
              (state_q inside {RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW}) &&
              (sat_inc(phase_cnt_q) == MAX_CNT);

`ifdef TLM_COUNTDOWN_CHECK_EN
    // First RED cycle is free; afterwards each sample must be one less
    // than the previous display value. Outside RED the display reads 0.
    if (nom_state == RED)
      cd_bad = (state_q == RED) && (dec_digit != digit_q - 4'd1);
    else
      cd_bad = (dec_digit != 4'd0);
`else
    cd_bad = 1'b0;
`endif

    if (lc == L_ILL)            cause = 3'd1;
    else if (!trans_ok)         cause = 3'd2;
    else if (dec_digit == 4'hF) cause = 3'd3;
    else if (cd_bad)            cause = 3'd4;
    else if (timeout)           cause = 3'd5;
    else                        cause = 3'd0;

    state_d     = (cause != 3'd0) ? UNSYNC : nom_state;
    phase_cnt_d = (state_d == state_q) ? sat_inc(phase_cnt_q) : 8'd1;
    digit_d     = dec_digit;

    // Only clean exits from a timed phase publish a duration.
    last_dur_d = last_dur_q;
    dur_stb_d  = 1'b0;
    if ((cause == 3'd0) && (state_d != state_q) &&
        (state_q != UNSYNC) && (state_q != IDLE_BLINK)) begin
      last_dur_d = phase_cnt_q;
      dur_stb_d  = 1'b1;
    end

    rounds_d = rounds_q;
    if ((cause == 3'd0) && (state_q == YELLOW) && (state_d == RED))
      rounds_d = rounds_q + 8'd1;

    // A new error overrides a simultaneous clear; otherwise the first code
    // since the last clear is kept.
    err_d      = err_q;
    err_code_d = err_code_q;
    if (cause != 3'd0) begin
      err_d = 1'b1;
      if (!err_q || bus.err_clr)
        err_code_d = cause;
    end else if (bus.err_clr) begin
      err_d      = 1'b0;
      err_code_d = 3'd0;
    end
  end

  assign bus.phase    = state_q;
  assign bus.digit    = digit_q;
  assign bus.last_dur = last_dur_q;
  assign bus.dur_stb  = dur_stb_q;
  assign bus.rounds   = rounds_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
// Directed bench for traffic_light_monitor: reset values, idle blinking,
// a full light round with phase durations, illegal transition, illegal lamp
// code with sticky/clear behaviour, timeout, mid-phase reset and the
// optional countdown check (TLM_COUNTDOWN_CHECK_EN).
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

  localparam logic [6:0] S0   = 7'b0111111;
  localparam logic [6:0] S5   = 7'b1101101;
  localparam logic [6:0] S8   = 7'b1111111;
  localparam logic [6:0] S9   = 7'b1101111;
  localparam logic [6:0] SBAD = 7'b0000000;

  localparam logic [2:0] LR   = 3'b100;
  localparam logic [2:0] LRY  = 3'b110;
  localparam logic [2:0] LG   = 3'b001;
  localparam logic [2:0] LY   = 3'b010;
  localparam logic [2:0] LD   = 3'b000;
  localparam logic [2:0] LBAD = 3'b111;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  traffic_light_monitor_if bus ();

  traffic_light_monitor #(.MAX_PHASE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, let the DUT register it, look 1 ns after the edge.
  task automatic step(input logic [2:0] l, input logic [6:0] s, input logic c);
    bus.lights  = l;
    bus.seg     = s;
    bus.err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n, input logic [2:0] l, input logic [6:0] s);
    for (int i = 0; i < n; i++) step(l, s, 1'b0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset: digit must stay 0 even though a valid 5 is on the display.
    rst = 1'b1;
    step(LD, S5, 1'b0);
    step(LD, S5, 1'b0);
    chk("rst_phase",    bus.phase,    0);
    chk("rst_digit",    bus.digit,    0);
    chk("rst_last_dur", bus.last_dur, 0);
    chk("rst_dur_stb",  bus.dur_stb,  0);
    chk("rst_rounds",   bus.rounds,   0);
    chk("rst_err",      bus.err,      0);
    chk("rst_err_code", bus.err_code, 0);
    rst = 1'b0;

`ifndef TLM_COUNTDOWN_CHECK_EN
    // Idle blinking yellow/dark, then red.
    step(LY, S0, 1'b0);
    chk("idle_phase_first", bus.phase, 6);
    for (int i = 0; i < 5; i++) step((i % 2 == 0) ? LD : LY, S0, 1'b0);
    chk("idle_phase_held", bus.phase, 6);
    chk("idle_err",        bus.err,   0);
    step(LR, S0, 1'b0);
    chk("idle_to_red",     bus.phase, 1);
    chk("idle_exit_nostb", bus.dur_stb, 0);

    // Full round: R10 RY4 G10 blink6 Y4 R.
    steps(9, LR, S0);
    step(LRY, S0, 1'b0);
    chk("ry_phase",     bus.phase,    2);
    chk("red_dur",      bus.last_dur, 10);
    chk("red_dur_stb",  bus.dur_stb,  1);
    steps(3, LRY, S0);
    chk("ry_stb_low",   bus.dur_stb,  0);
    step(LG, S0, 1'b0);
    chk("g_phase",      bus.phase,    3);
    chk("ry_dur",       bus.last_dur, 4);
    chk("ry_dur_stb",   bus.dur_stb,  1);
    steps(9, LG, S0);
    step(LD, S0, 1'b0);
    chk("gb_phase",     bus.phase,    4);
    chk("g_dur",        bus.last_dur, 10);
    chk("g_dur_stb",    bus.dur_stb,  1);
    for (int i = 0; i < 5; i++) step((i % 2 == 0) ? LG : LD, S0, 1'b0);
    chk("gb_held",      bus.phase,    4);
    step(LY, S0, 1'b0);
    chk("y_phase",      bus.phase,    5);
    chk("gb_dur",       bus.last_dur, 6);
    chk("gb_dur_stb",   bus.dur_stb,  1);
    steps(3, LY, S0);
    step(LR, S0, 1'b0);
    chk("round_phase",  bus.phase,    1);
    chk("y_dur",        bus.last_dur, 4);
    chk("y_dur_stb",    bus.dur_stb,  1);
    chk("rounds_1",     bus.rounds,   1);
    chk("round_err",    bus.err,      0);

    // Illegal transition GREEN -> RED, then resync on red.
    step(LRY, S0, 1'b0);
    step(LG, S0, 1'b0);
    step(LR, S0, 1'b0);
    chk("ilt_err",      bus.err,      1);
    chk("ilt_code",     bus.err_code, 2);
    chk("ilt_phase",    bus.phase,    0);
    chk("ilt_nostb",    bus.dur_stb,  0);
    step(LR, S0, 1'b0);
    chk("ilt_resync",   bus.phase,    1);
    chk("ilt_sticky",   bus.err_code, 2);
    chk("ilt_rounds",   bus.rounds,   1);
    step(LR, S0, 1'b1);
    chk("clr1_err",     bus.err,      0);
    chk("clr1_code",    bus.err_code, 0);

    // Illegal lamps and bad segments together: lamp error wins.
    step(LBAD, SBAD, 1'b0);
    chk("ill_err",      bus.err,      1);
    chk("ill_code",     bus.err_code, 1);
    chk("ill_phase",    bus.phase,    0);
    chk("ill_digit",    bus.digit,    15);
    step(LD, SBAD, 1'b0);
    chk("first_kept",   bus.err_code, 1);
    chk("first_phase",  bus.phase,    0);
    step(LR, SBAD, 1'b1);
    chk("clr_new_err",  bus.err,      1);
    chk("clr_new_code", bus.err_code, 3);
    step(LR, S0, 1'b1);
    chk("clr2_err",     bus.err,      0);
    chk("clr2_code",    bus.err_code, 0);
    chk("clr2_phase",   bus.phase,    1);
    chk("clr2_digit",   bus.digit,    0);

    // Timeout: red held until the count reaches 32.
    steps(30, LR, S0);
    chk("to_before_err",   bus.err,   0);
    chk("to_before_phase", bus.phase, 1);
    step(LR, S0, 1'b0);
    chk("to_err",       bus.err,      1);
    chk("to_code",      bus.err_code, 5);
    chk("to_phase",     bus.phase,    0);
    step(LR, S0, 1'b1);
    chk("to_clr_err",   bus.err,      0);
    chk("to_clr_phase", bus.phase,    1);

    // Reset mid-phase discards the partial duration.
    steps(2, LR, S0);
    rst = 1'b1;
    step(LRY, S0, 1'b0);
    chk("mid_rst_phase",  bus.phase,    0);
    chk("mid_rst_dur",    bus.last_dur, 0);
    chk("mid_rst_stb",    bus.dur_stb,  0);
    chk("mid_rst_rounds", bus.rounds,   0);
    rst = 1'b0;
`endif

    // Countdown on the display while red: 9, 8, 8.
    step(LR, S9, 1'b0);
    chk("cd_phase",   bus.phase, 1);
    chk("cd_digit9",  bus.digit, 9);
    step(LR, S8, 1'b0);
    chk("cd_ok_err",  bus.err,   0);
    step(LR, S8, 1'b0);
`ifdef TLM_COUNTDOWN_CHECK_EN
    chk("cd_err",     bus.err,      1);
    chk("cd_code",    bus.err_code, 4);
    chk("cd_phase0",  bus.phase,    0);
`else
    chk("cd_err",     bus.err,      0);
    chk("cd_phase1",  bus.phase,    1);
    chk("cd_digit8",  bus.digit,    8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
